// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control bundle type and forwarding selects
// for the RV32I pipeline control path.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       upper;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Main-control decode: opcode to control bundle plus source-register usage.
module control_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    ctrl_o     = CTRL_NOP;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    unique case (opcode_i)
      OP_R: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = 2'b10;
        uses_rs1_o      = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = 2'b11;
        uses_rs1_o      = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
        uses_rs1_o      = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        uses_rs1_o      = 1'b1;
        uses_rs2_o      = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.aluop  = 2'b01;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.aluop    = 2'b11;
      end
      OP_JALR: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.aluop    = 2'b11;
        uses_rs1_o      = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        // Upper-immediate forms are optional; without them they trap as illegal.
        if (EN_UPPER) begin
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.upper    = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main control, load-use hazard detection and EX forwarding
// selects for the 5-stage RV32I core.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit EN_UPPER   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  ex_valid,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_upper,
  output logic                  ex_illegal,
  output logic [1:0]            ex_aluop,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  ctrl_t                 id_ctrl;
  logic                  id_use1, id_use2;
  logic [REG_ADDR_W-1:0] id_rd, id_rs1, id_rs2;
  logic                  unused_instr;

  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                  ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;

  logic                  mem_regwrite_q, mem_memtoreg_q, mem_memread_q, mem_memwrite_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  wb_regwrite_q, wb_memtoreg_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic                  bubble;

  control_decode #(.EN_UPPER(EN_UPPER)) u_decode (
    .opcode_i   (id_instr[6:0]),
    .ctrl_o     (id_ctrl),
    .uses_rs1_o (id_use1),
    .uses_rs2_o (id_use2)
  );

  assign id_rd        = id_instr[7 +: REG_ADDR_W];
  assign id_rs1       = id_instr[15 +: REG_ADDR_W];
  assign id_rs2       = id_instr[20 +: REG_ADDR_W];
  assign unused_instr = ^{id_instr[31:25], id_instr[14:12]};

  // Flush masks the stall so a squashed consumer never holds the front end.
  always_comb begin
    stall_o = 1'b0;
    if (!flush_i && id_valid && ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0)) begin
      stall_o = (id_use1 && (id_rs1 == ex_rd_q)) || (id_use2 && (id_rs2 == ex_rd_q));
    end
  end

  assign bubble = stall_o || flush_i || !id_valid;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = CTRL_NOP;
    ex_rd_d    = '0;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    ex_use1_d  = 1'b0;
    ex_use2_d  = 1'b0;
    if (!bubble) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_ctrl.regwrite ? id_rd : '0;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_use1_d  = id_use1;
      ex_use2_d  = id_use2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= CTRL_NOP;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_use1_q      <= 1'b0;
      ex_use2_q      <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_use1_q      <= ex_use1_d;
      ex_use2_q      <= ex_use2_d;
      mem_regwrite_q <= ex_ctrl_q.regwrite;
      mem_memtoreg_q <= ex_ctrl_q.memtoreg;
      mem_memread_q  <= ex_ctrl_q.memread;
      mem_memwrite_q <= ex_ctrl_q.memwrite;
      mem_rd_q       <= ex_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_use1_q) begin
      if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) fwd_a = FWD_MEM;
      else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) fwd_a = FWD_WB;
    end
    if (ex_use2_q) begin
      if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) fwd_b = FWD_MEM;
      else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) fwd_b = FWD_WB;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_alusrc    = ex_ctrl_q.alusrc;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_jump      = ex_ctrl_q.jump;
  assign ex_upper     = ex_ctrl_q.upper;
  assign ex_illegal   = ex_ctrl_q.illegal;
  assign ex_aluop     = ex_ctrl_q.aluop;
  assign mem_memread  = mem_memread_q;
  assign mem_memwrite = mem_memwrite_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: expectations are queued with the cycle
// they fall due and compared when the pipeline reaches that cycle.
module tb_control_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic        flush_i = 1'b0;

  logic       stall_o, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_upper, ex_illegal;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic [4:0] wb_rd;

  logic       nu_stall, nu_ex_valid, nu_ex_alusrc, nu_ex_branch, nu_ex_jump, nu_ex_upper, nu_ex_illegal;
  logic [1:0] nu_ex_aluop, nu_fwd_a, nu_fwd_b;
  logic       nu_mem_memread, nu_mem_memwrite, nu_wb_regwrite, nu_wb_memtoreg;
  logic [4:0] nu_wb_rd;

  always #5 clk = ~clk;

  control_pipe #(.REG_ADDR_W(5), .EN_UPPER(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_upper(ex_upper), .ex_illegal(ex_illegal), .ex_aluop(ex_aluop),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
  );

  control_pipe #(.REG_ADDR_W(5), .EN_UPPER(1'b0)) u_dut_nu (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush_i(flush_i),
    .stall_o(nu_stall), .ex_valid(nu_ex_valid), .ex_alusrc(nu_ex_alusrc), .ex_branch(nu_ex_branch),
    .ex_jump(nu_ex_jump), .ex_upper(nu_ex_upper), .ex_illegal(nu_ex_illegal), .ex_aluop(nu_ex_aluop),
    .fwd_a(nu_fwd_a), .fwd_b(nu_fwd_b), .mem_memread(nu_mem_memread), .mem_memwrite(nu_mem_memwrite),
    .wb_regwrite(nu_wb_regwrite), .wb_memtoreg(nu_wb_memtoreg), .wb_rd(nu_wb_rd)
  );

  localparam int S_STALL = 0;
  localparam int S_FWD   = 1;  // {fwd_a, fwd_b}
  localparam int S_EX    = 2;  // {valid, alusrc, branch, jump, upper, illegal, aluop}
  localparam int S_MEM   = 3;  // {memread, memwrite}
  localparam int S_WB    = 4;  // {regwrite, memtoreg, rd}
  localparam int S_EX_NU = 5;  // EX group of the EN_UPPER=0 instance

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] val;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_STALL: return {15'd0, stall_o};
      S_FWD:   return {12'd0, fwd_a, fwd_b};
      S_EX:    return {8'd0, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_upper, ex_illegal, ex_aluop};
      S_MEM:   return {14'd0, mem_memread, mem_memwrite};
      S_WB:    return {9'd0, wb_regwrite, wb_memtoreg, wb_rd};
      S_EX_NU: return {8'd0, nu_ex_valid, nu_ex_alusrc, nu_ex_branch, nu_ex_jump, nu_ex_upper,
                       nu_ex_illegal, nu_ex_aluop};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic sb_push(input int ofs, input int sel, input logic [15:0] val, input string tag);
    sb_t e;
    e.due = cyc + ofs;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // One pipeline cycle: drive ID at the falling edge, then settle and
  // compare everything due in this cycle before the next rising edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic fl);
    @(negedge clk);
    rst_n    = rst;
    id_valid = v;
    id_instr = ins;
    flush_i  = fl;
    #1;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].val);
        sb_q.delete(i);
      end
    end
    cyc++;
  endtask

  task automatic issue(input logic [31:0] ins, input logic fl = 1'b0);
    step(1'b1, 1'b1, ins, fl);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, op};
  endfunction

  function automatic logic [31:0] enc_sb(input logic [6:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, op};
  endfunction

  logic [31:0] add_x3, lw_x5, add_x6, add_x4, add_x8, sub_x7, add_x0, sub_x0, lw_x0, add_x9;
  logic [31:0] lui_x11, sw_i;
  logic [31:0] dec_ins[7];
  logic [15:0] dec_ex[7];
  logic [15:0] dec_nu[7];

  initial begin
    add_x3  = enc_r(7'd0, 5'd3, 5'd1, 5'd2);
    lw_x5   = enc_i(7'b0000011, 5'd5, 5'd1);
    add_x6  = enc_r(7'd0, 5'd6, 5'd5, 5'd2);
    add_x4  = enc_r(7'd0, 5'd4, 5'd1, 5'd2);
    add_x8  = enc_r(7'd0, 5'd8, 5'd1, 5'd2);
    sub_x7  = enc_r(7'b0100000, 5'd7, 5'd4, 5'd4);
    add_x0  = enc_r(7'd0, 5'd0, 5'd1, 5'd2);
    sub_x0  = enc_r(7'b0100000, 5'd7, 5'd0, 5'd0);
    lw_x0   = enc_i(7'b0000011, 5'd0, 5'd1);
    add_x9  = enc_r(7'd0, 5'd9, 5'd0, 5'd0);
    lui_x11 = {7'd0, 5'd4, 5'd4, 3'd0, 5'd11, 7'b0110111};  // rs fields alias x4
    sw_i    = enc_sb(7'b0100011, 5'd1, 5'd2);

    dec_ins[0] = enc_i(7'b0010011, 5'd12, 5'd1);  dec_ex[0] = 16'h00C3; dec_nu[0] = 16'h00C3;
    dec_ins[1] = enc_sb(7'b1100011, 5'd1, 5'd2);  dec_ex[1] = 16'h00A1; dec_nu[1] = 16'h00A1;
    dec_ins[2] = {25'd0, 5'd14, 7'b1101111} >> 0; dec_ex[2] = 16'h0093; dec_nu[2] = 16'h0093;
    dec_ins[3] = enc_i(7'b1100111, 5'd13, 5'd2);  dec_ex[3] = 16'h00D3; dec_nu[3] = 16'h00D3;
    dec_ins[4] = {20'h12345, 5'd15, 7'b0010111};  dec_ex[4] = 16'h00C8; dec_nu[4] = 16'h0084;
    dec_ins[5] = {25'd0, 7'b1111111};             dec_ex[5] = 16'h0084; dec_nu[5] = 16'h0084;
    dec_ins[6] = sw_i;                            dec_ex[6] = 16'h00C0; dec_nu[6] = 16'h00C0;
    dec_ins[2] = {20'd0, 5'd14, 7'b1101111};

    // Reset: everything reads zero once a reset edge has passed.
    step(1'b0, 1'b0, 32'd0, 1'b0);
    sb_push(0, S_EX, 16'h0000, "rst_ex");
    sb_push(0, S_MEM, 16'h0000, "rst_mem");
    sb_push(0, S_WB, 16'h0000, "rst_wb");
    sb_push(0, S_STALL, 16'h0000, "rst_stall");
    sb_push(0, S_FWD, 16'h0000, "rst_fwd");
    step(1'b0, 1'b0, 32'd0, 1'b0);
    nops(1);

    // R-type latency through EX and WB.
    sb_push(1, S_EX, 16'h0082, "add_ex");
    sb_push(1, S_FWD, 16'h0000, "add_fwd");
    sb_push(3, S_WB, 16'h0043, "add_wb");
    issue(add_x3);
    nops(3);

    // Load-use: one stall cycle, a bubble, then WB forwarding.
    sb_push(1, S_STALL, 16'h0001, "lu_stall");
    sb_push(1, S_EX, 16'h00C0, "lw_ex");
    issue(lw_x5);
    sb_push(1, S_EX, 16'h0000, "lu_bubble");
    sb_push(1, S_MEM, 16'h0002, "lw_mem");
    sb_push(1, S_STALL, 16'h0000, "lu_stall_once");
    sb_push(2, S_FWD, 16'h0004, "lu_fwd");
    sb_push(2, S_WB, 16'h0065, "lw_wb");
    issue(add_x6);
    sb_push(1, S_EX, 16'h0082, "lu_add_ex");
    sb_push(3, S_WB, 16'h0046, "lu_add_wb");
    issue(add_x6);
    nops(3);

    // Forwarding from MEM, from WB, MEM priority, x0 and unused sources.
    issue(add_x4);
    sb_push(0, S_STALL, 16'h0000, "alu_nostall");
    sb_push(1, S_FWD, 16'h000A, "fwd_mem");
    issue(sub_x7);
    nops(3);

    issue(add_x4);
    issue(add_x8);
    sb_push(1, S_FWD, 16'h0005, "fwd_wb");
    issue(sub_x7);
    nops(3);

    issue(add_x4);
    issue(add_x4);
    sb_push(1, S_FWD, 16'h000A, "fwd_prio");
    issue(sub_x7);
    nops(3);

    issue(add_x0);
    sb_push(1, S_FWD, 16'h0000, "fwd_x0");
    issue(sub_x0);
    nops(3);

    issue(lw_x0);
    sb_push(0, S_STALL, 16'h0000, "stall_x0");
    issue(add_x9);
    nops(3);

    issue(add_x4);
    sb_push(1, S_FWD, 16'h0000, "fwd_unused");
    sb_push(1, S_EX, 16'h00C8, "lui_ex");
    sb_push(1, S_EX_NU, 16'h0084, "lui_nu_ex");
    issue(lui_x11);
    nops(3);

    // Decode coverage for the remaining opcode classes.
    for (int i = 0; i < 7; i++) begin
      sb_push(1, S_EX, dec_ex[i], $sformatf("dec%0d_ex", i));
      sb_push(1, S_EX_NU, dec_nu[i], $sformatf("dec%0d_nu_ex", i));
      issue(dec_ins[i]);
    end
    sb_push(1, S_MEM, 16'h0001, "sw_mem");
    nops(3);

    // Flush beats stall: consumer squashed, load still advances.
    issue(lw_x5);
    sb_push(0, S_STALL, 16'h0000, "flush_stall");
    sb_push(1, S_EX, 16'h0000, "flush_bubble");
    sb_push(1, S_MEM, 16'h0002, "flush_lw_mem");
    sb_push(2, S_WB, 16'h0065, "flush_lw_wb");
    sb_push(3, S_WB, 16'h0000, "flush_no_wb");
    issue(add_x6, 1'b1);
    nops(4);

    // Reset with a store in MEM and a load in EX discards both.
    issue(sw_i);
    issue(lw_x5);
    sb_push(0, S_MEM, 16'h0001, "pre_rst_mem");
    sb_push(1, S_MEM, 16'h0000, "rst_mid_mem");
    sb_push(1, S_WB, 16'h0000, "rst_mid_wb");
    sb_push(1, S_EX, 16'h0000, "rst_mid_ex");
    sb_push(2, S_MEM, 16'h0000, "rst_mid_mem2");
    sb_push(2, S_WB, 16'h0000, "rst_mid_wb2");
    step(1'b0, 1'b0, 32'd0, 1'b0);
    nops(4);

    check("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined main-control and hazard unit for the 5-stage RV32I core. Decodes the instruction in ID into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and raises a stall, inserts bubbles on stall and branch flush, and produces forwarding selects for the EX operand muxes.

## Interface
- `REG_ADDR_W`, 5: register-index width.
- `EN_UPPER`, 1: when 1, decode LUI/AUIPC; when 0, they decode as illegal.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_instr` in 32: instruction in ID.
- `flush_i` in 1: branch/jump taken, resolved in EX.
- `stall_o` out 1: load-use stall; hold PC and IF/ID.
- `ex_valid`, `ex_alusrc`, `ex_branch`, `ex_jump`, `ex_upper`, `ex_illegal` out 1 each: EX-stage control.
- `ex_aluop` out 2: EX ALU op class.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = regfile, 10 = MEM result, 01 = WB result.
- `mem_memread`, `mem_memwrite` out 1 each: MEM-stage control.
- `wb_regwrite`, `wb_memtoreg` out 1 each; `wb_rd` out REG_ADDR_W: WB-stage control.

## Operation
- **Decode bundle** {alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, upper, aluop[1:0], illegal}. All unlisted bits are 0.
  - R (0110011): regwrite, aluop 10.
  - I-arith (0010011): alusrc, regwrite, aluop 11.
  - Load (0000011): alusrc, memtoreg, regwrite, memread, aluop 00.
  - Store (0100011): alusrc, memwrite, aluop 00.
  - Branch (1100011): branch, aluop 01.
  - JAL (1101111): regwrite, jump, aluop 11.
  - JALR (1100111): alusrc, regwrite, jump, aluop 11.
  - LUI (0110111) and AUIPC (0010111), only if EN_UPPER: alusrc, regwrite, upper, aluop 00.
  - Any other opcode: illegal=1, all else 0.
  - Don't-care bits are driven 0, never X.
- **Register uses.** rs1 is used by R, I, load, store, branch and JALR. rs2 is used by R, store and branch. rd is valid whenever regwrite=1.
- **Load-use stall.** `stall_o` = id_valid & ex_valid & ex memread & ex_rd≠0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- **Bubble.** A bubble has valid=0 and all control bits 0. A bubble enters ID/EX when `stall_o`, `flush_i` or !id_valid.
- **Flush priority.** Flush beats stall: `stall_o` is forced 0 when `flush_i`=1.
- **Downstream never stalls.** EX→MEM and MEM→WB advance every cycle.
- **Forwarding** for each EX source, with uses_rsX held in ID/EX:
  - MEM regwrite & mem_rd≠0 & mem_rd==ex_rsX → 10.
  - Else WB regwrite & wb_rd≠0 & wb_rd==ex_rsX → 01.
  - Else → 00.
  - MEM has priority over WB.
  - An unused source always selects 00.

## Timing
- **Latency.** An instruction in ID at cycle n appears in EX at n+1, MEM at n+2, WB at n+3.
- **Combinational outputs.** `stall_o` and `fwd_a`/`fwd_b` are combinational from the current pipeline registers and ID; they are valid in the same cycle.
- **Registered outputs.** All other outputs come directly from registers.
- **Reset.** With rst_n=0 at a rising edge, every stage register, valid bit, rd and rs field clears to 0. All outputs read 0 the cycle after reset. Reset mid-operation discards all in-flight instructions with no partial writes.
- **Simultaneous flush and stall.** Flush wins: one bubble enters EX and the EX load still advances to MEM.
- **Stall duration.** A load-use stall lasts exactly one cycle, because the load has moved to MEM on the next cycle.
- **x0 handling.** rd=0 never forwards and never stalls.

## Structure
- **Package `ctrl_pkg`:**
  - opcode localparams;
  - `ctrl_t` bundle typedef (field order as in the decode bundle);
  - forward-select constants FWD_RF/FWD_MEM/FWD_WB;
  - bubble constant `CTRL_NOP`.
- **Sub-module `control_decode`:** combinational, opcode/instr → `ctrl_t` plus uses_rs1/uses_rs2. `control_pipe` instantiates it once.

## Test plan
- Reset, then R-type `add x3,x1,x2` → ex_aluop=10 at n+1, wb_regwrite=1 and wb_rd=3 at n+3; every output 0 during reset.
- `lw x5,0(x1)` then `add x6,x5,x2` → stall_o=1 for one cycle, bubble in EX (ex_valid=0), then fwd_a=01 when the add reaches EX.
- `add x4,..` then `sub x7,x4,x4` → fwd_a=fwd_b=10. With one intervening instruction → fwd_a=fwd_b=01. Writing to x0 → 00.
- flush_i=1 while ID holds a load-use consumer → stall_o=0, ex_valid=0 next cycle, no register write reaches WB.
- Opcode 0110111 with EN_UPPER=1 → ex_upper=1, ex_alusrc=1. With EN_UPPER=0 → ex_illegal=1 and all other control 0. Opcode 1111111 → ex_illegal=1.
- rst_n=0 asserted with load/store in MEM → mem_memwrite/mem_memread=0 on the next cycle.
